// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam logic [1:0] STEP_FORWARD                = 2'b00;
  localparam logic [1:0] JUMP_TO_LABEL               = 2'b01;
  localparam logic [1:0] JUMP_TO_CALCULATED_REGISTER = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'b00,
    WAIT = 2'b01,
    HOLD = 2'b10,
    KILL = 2'b11
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// Combinational next-PC selection from the EX redirect interface.
module next_pc_sel
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] target_address,
  input  logic [31:0] alu_result,
  input  logic [1:0]  pc_next_select,
  output logic [31:0] next_pc,
  output logic        redirect
);

  always_comb begin
    next_pc  = pc + 32'd4;
    redirect = 1'b0;
    case (pc_next_select)
      JUMP_TO_LABEL: begin
        next_pc  = target_address;
        redirect = 1'b1;
      end
      // JALR targets always have bit 0 cleared.
      JUMP_TO_CALCULATED_REGISTER: begin
        next_pc  = {alu_result[31:1], 1'b0};
        redirect = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request,
// and fills the IF/ID register while honouring stall and redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  PCNext_select,
  input  logic [31:0] Target_Address,
  input  logic [31:0] ALUResult,
  input  logic        Stall,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        IFID_valid,
  output logic [31:0] IFID_instr,
  output logic [31:0] IFID_PC,
  output logic [31:0] IFID_PCPlus4,
  output logic        Redirect_flush,
  output logic [1:0]  dbg_state
);

  // Handshake: a request transfers on a rising edge where imem_req_valid and
  // imem_req_ready are both high; imem_rsp_valid is a one-cycle pulse per
  // accepted request, in order, never in the same cycle as its acceptance.

  fetch_state_t state, state_d;
  logic [31:0]  pc, pc_d;
  logic [31:0]  next_pc;
  logic         redirect;
  logic [31:0]  hold_instr, hold_pc;
  logic         load_rsp, load_hold, capture_hold;

  next_pc_sel u_next_pc_sel (
    .pc             (pc),
    .target_address (Target_Address),
    .alu_result     (ALUResult),
    .pc_next_select (PCNext_select),
    .next_pc        (next_pc),
    .redirect       (redirect)
  );

  assign Redirect_flush = redirect;
  assign imem_req_valid = rst_n && (state == REQ);
  assign imem_req_addr  = pc;
  assign dbg_state      = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= REQ;
      pc    <= RESET_PC;
    end else begin
      state <= state_d;
      pc    <= pc_d;
    end
  end

  always_comb begin
    state_d      = state;
    pc_d         = pc;
    load_rsp     = 1'b0;
    load_hold    = 1'b0;
    capture_hold = 1'b0;
    case (state)
      REQ: begin
        if (redirect) pc_d = next_pc;
        if (imem_req_ready) state_d = redirect ? KILL : WAIT;
      end
      WAIT: begin
        if (redirect) begin
          pc_d    = next_pc;
          state_d = imem_rsp_valid ? REQ : KILL;
        end else if (imem_rsp_valid) begin
          pc_d = next_pc;
          if (Stall) begin
            capture_hold = 1'b1;
            state_d      = HOLD;
          end else begin
            load_rsp = 1'b1;
            state_d  = REQ;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = next_pc;
          state_d = REQ;
        end else if (!Stall) begin
          load_hold = 1'b1;
          state_d   = REQ;
        end
      end
      KILL: begin
        // A redirect here only retargets the PC; the stale response is still owed.
        if (redirect) pc_d = next_pc;
        if (imem_rsp_valid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_instr <= NOP_INSTR;
      hold_pc    <= 32'h0;
    end else if (capture_hold) begin
      hold_instr <= imem_rsp_data;
      hold_pc    <= pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IFID_valid   <= 1'b0;
      IFID_instr   <= NOP_INSTR;
      IFID_PC      <= 32'h0;
      IFID_PCPlus4 <= 32'h0;
    end else if (redirect) begin
      IFID_valid <= 1'b0;
    end else if (!Stall) begin
      if (load_rsp) begin
        IFID_valid   <= 1'b1;
        IFID_instr   <= imem_rsp_data;
        IFID_PC      <= pc;
        IFID_PCPlus4 <= pc + 32'd4;
      end else if (load_hold) begin
        IFID_valid   <= 1'b1;
        IFID_instr   <= hold_instr;
        IFID_PC      <= hold_pc;
        IFID_PCPlus4 <= hold_pc + 32'd4;
      end else begin
        // No new instruction this cycle: ID sees a bubble.
        IFID_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: memory model, stream-level reference, scoreboard.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic [1:0]  pc_next_select;
  logic [31:0] target_address, alu_result;
  logic        stall;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        ifid_valid, redirect_flush;
  logic [31:0] ifid_instr, ifid_pc, ifid_pc_plus4;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int deliveries = 0;
  bit in_reset = 1'b1;

  // Scoreboard: head is the address of the next instruction the stream must deliver.
  logic [31:0] exp_q[$];

  bit          pend;
  logic [31:0] pend_addr;
  int          pend_wait;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .PCNext_select  (pc_next_select),
    .Target_Address (target_address),
    .ALUResult      (alu_result),
    .Stall          (stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .IFID_valid     (ifid_valid),
    .IFID_instr     (ifid_instr),
    .IFID_PC        (ifid_pc),
    .IFID_PCPlus4   (ifid_pc_plus4),
    .Redirect_flush (redirect_flush),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] redirect_target(input logic [1:0] sel,
                                                  input logic [31:0] tgt,
                                                  input logic [31:0] alu);
    if (sel == 2'b01) return tgt;
    return {alu[31:1], 1'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- driver / memory model ----------------
  task automatic step(input int p_stall, input int p_redir, input int p_ready, input int max_lat);
    bit had_pend;
    @(negedge clk);
    had_pend       = pend;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (pend) begin
      if (pend_wait == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr);
        pend           = 1'b0;
      end else begin
        pend_wait--;
      end
    end
    imem_req_ready = ($urandom_range(99) < p_ready);
    if (imem_req_valid) check("one_outstanding", {31'h0, had_pend}, 32'h0);
    if (imem_req_valid && imem_req_ready) begin
      pend      = 1'b1;
      pend_addr = imem_req_addr;
      pend_wait = $urandom_range(max_lat - 1, 0);
    end
    stall = ($urandom_range(99) < p_stall);
    if ($urandom_range(99) < p_redir) pc_next_select = 2'($urandom_range(2, 1));
    else pc_next_select = ($urandom_range(19) == 0) ? 2'b11 : 2'b00;
    case ($urandom_range(3))
      0:       target_address = 32'h200 + 32'($urandom_range(63) << 2);
      1:       target_address = 32'hFFFF_FFF8;
      2:       target_address = 32'h400;
      default: target_address = $urandom;
    endcase
    alu_result = $urandom;
    #1;
    check("redirect_flush", {31'h0, redirect_flush},
          {31'h0, (pc_next_select == 2'b01) || (pc_next_select == 2'b10)});
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic        prev_valid;
  logic [31:0] prev_instr, prev_pc, prev_pc4;

  always @(posedge clk) begin
    #1;
    if (!in_reset) begin
      if (pc_next_select == 2'b01 || pc_next_select == 2'b10) begin
        check("flush_clears_valid", {31'h0, ifid_valid}, 32'h0);
        exp_q.delete();
        exp_q.push_back(redirect_target(pc_next_select, target_address, alu_result));
      end else if (stall) begin
        check("stall_valid", {31'h0, ifid_valid}, {31'h0, prev_valid});
        check("stall_instr", ifid_instr, prev_instr);
        check("stall_pc", ifid_pc, prev_pc);
        check("stall_pc4", ifid_pc_plus4, prev_pc4);
      end else if (ifid_valid) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        deliveries++;
        check("ifid_pc", ifid_pc, e);
        check("ifid_instr", ifid_instr, mem_word(e));
        check("ifid_pc4", ifid_pc_plus4, e + 32'd4);
        exp_q.push_back(e + 32'd4);
      end
      if (imem_req_valid) check("req_addr", imem_req_addr, exp_q[0]);
    end
    prev_valid = ifid_valid;
    prev_instr = ifid_instr;
    prev_pc    = ifid_pc;
    prev_pc4   = ifid_pc_plus4;
  end

  // ---------------- stimulus sequence ----------------
  task automatic reset_checks(input string tag);
    check({tag, "_req_valid"}, {31'h0, imem_req_valid}, 32'h0);
    check({tag, "_ifid_valid"}, {31'h0, ifid_valid}, 32'h0);
    check({tag, "_ifid_instr"}, ifid_instr, NOP_INSTR);
    check({tag, "_ifid_pc"}, ifid_pc, 32'h0);
    check({tag, "_ifid_pc4"}, ifid_pc_plus4, 32'h0);
    check({tag, "_state"}, {30'h0, dbg_state}, {30'h0, REQ});
  endtask

  initial begin
    rst_n          = 1'b0;
    in_reset       = 1'b1;
    pc_next_select = 2'b00;
    target_address = 32'h0;
    alu_result     = 32'h0;
    stall          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    pend           = 1'b0;
    pend_addr      = 32'h0;
    pend_wait      = 0;
    exp_q.push_back(RST_PC);
    repeat (2) @(negedge clk);
    reset_checks("por");
    rst_n    = 1'b1;
    in_reset = 1'b0;

    // Back-to-back fetch, ready=1, latency 1, no hazards.
    repeat (12) step(0, 0, 100, 1);
    repeat (1500) step(25, 8, 70, 3);

    // Asynchronous reset while a request is outstanding.
    begin
      int n;
      n = 0;
      while (!pend && n < 50) begin
        step(0, 0, 100, 3);
        n++;
      end
      check("wait_reached", {31'h0, pend}, 32'h1);
      #2;
      rst_n    = 1'b0;
      in_reset = 1'b1;
      #1;
      reset_checks("async");
      pend           = 1'b0;
      imem_rsp_valid = 1'b0;
      pc_next_select = 2'b00;
      stall          = 1'b0;
      exp_q.delete();
      exp_q.push_back(RST_PC);
      repeat (2) @(negedge clk);
      rst_n    = 1'b1;
      in_reset = 1'b0;
      #1;
      check("post_reset_addr", imem_req_addr, RST_PC);
    end

    repeat (1500) step(10, 4, 90, 2);
    repeat (4) step(0, 0, 100, 1);

    checks++;
    if (deliveries < 200) begin
      failures++;
      $display("FAIL delivery_count: got %0d expected at least 200", deliveries);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage. It consumes the EX-stage redirect interface: PCNext_select, the branch/JAL target and the JALR target.
- Owns the architectural PC and issues single-outstanding requests to instruction memory over a valid/ready request channel and a valid response channel.
- Delivers fetched instructions into the IF/ID pipeline register, honouring stall and flush.
- Emits Redirect_flush so younger ID/EX contents can be squashed.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- PCNext_select  in  2  EX decision: STEP_FORWARD=2'b00, JUMP_TO_LABEL=2'b01, JUMP_TO_CALCULATED_REGISTER=2'b10; 2'b11 is treated as STEP_FORWARD.
- Target_Address  in  32  PC+imm from EX (branch/JAL target).
- ALUResult  in  32  rs1+imm from EX (JALR target).
- Stall  in  1  hazard unit: hold IF/ID.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch address (= PC).
- imem_req_ready  in  1  memory accepts request.
- imem_rsp_valid  in  1  response valid (one per accepted request, in order, latency ≥1).
- imem_rsp_data  in  32  instruction word.
- IFID_valid  out  1  IF/ID holds a live instruction.
- IFID_instr  out  32  instruction.
- IFID_PC  out  32  address of IFID_instr.
- IFID_PCPlus4  out  32  IFID_PC+4.
- Redirect_flush  out  1  combinational; 1 when PCNext_select is JUMP_TO_LABEL or JUMP_TO_CALCULATED_REGISTER.

Behaviour:
- Reset (async, immediate):
  - PC=RESET_PC, state=REQ.
  - imem_req_valid=0 while rst_n=0.
  - IFID_valid=0, IFID_instr=32'h0000_0013 (NOP), IFID_PC=0, IFID_PCPlus4=0.
  - Hold buffer empty.
  - Instruction memory is reset by the same rst_n; no stale response survives reset.
- Redirect target:
  - JUMP_TO_LABEL uses Target_Address.
  - JUMP_TO_CALCULATED_REGISTER uses {ALUResult[31:1],1'b0}.
  - Bits [1:0] are otherwise passed through unchecked.
- Sequential PC: PC+4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0).
- States:
  - REQ:
    - imem_req_valid=1, imem_req_addr=PC.
    - The address may change while not yet accepted (redirect).
    - On valid&ready: WAIT.
  - WAIT: awaiting response.
    - On rsp_valid with Stall=0: load IF/ID (valid=1, instr, PC, PC+4), PC<=PC+4, go to REQ.
    - On rsp_valid with Stall=1: capture into hold buffer, PC<=PC+4, go to HOLD.
  - HOLD:
    - No request issued (imem_req_valid=0).
    - When Stall=0: load IF/ID from the buffer, go to REQ.
  - KILL:
    - Request is in flight but stale; no request issued.
    - On rsp_valid: drop the response, go to REQ.
- Redirect priority: redirect > Stall > normal.
  - On any redirect: PC<=target, and IFID_valid<=0 at the next edge, regardless of Stall.
  - REQ, not accepted: next cycle requests the target.
  - REQ, accepted the same cycle: go to KILL.
  - WAIT, no rsp_valid: go to KILL.
  - WAIT with rsp_valid the same cycle: drop the response, go to REQ.
  - HOLD: discard the buffer, go to REQ.
  - KILL: update PC, stay in KILL.
- Stall without redirect: IF/ID registers are unchanged, including IFID_valid.
- Latency: request accepted at cycle N, response at cycle N+L → IF/ID valid at N+L+1.
  - With L=1 and ready=1, throughput is one instruction per 2 cycles.
  - This is accepted for this revision.
- At most one outstanding request at any time.

Decomposition:
- Pkg additions:
  - fetch_state_t enum {REQ, WAIT, HOLD, KILL}.
  - NOP_INSTR = 32'h0000_0013.
  - The existing STEP_FORWARD / JUMP_TO_LABEL / JUMP_TO_CALCULATED_REGISTER constants.
- Sub-module next_pc_sel: combinational target select and JALR LSB clear. Inputs: PC, Target_Address, ALUResult, PCNext_select. Outputs: next PC, redirect flag.
- The FSM, hold buffer and IF/ID registers stay in fetch_unit.

Test Plan:
- Reset release, RESET_PC=0x100, ready=1, L=1 → request addrs 0x100, 0x104, 0x108 on alternate cycles; IFID_PC follows; IFID_PCPlus4=0x104, 0x108, 0x10C; IFID_instr matches memory.
- In WAIT, PCNext_select=01, Target_Address=0x200 → Redirect_flush=1 that cycle; state KILL; later response dropped (IFID_valid=0); next request addr 0x200.
- PCNext_select=10, ALUResult=0x0000_0305 → Redirect_flush=1; next request addr 0x304.
- Stall=1 for 3 cycles spanning rsp_valid (data 0xDEADBEEF) → IF/ID unchanged, imem_req_valid=0 in HOLD; on Stall=0, IFID_instr=0xDEADBEEF next edge, then request PC+4.
- Redirect (01, target 0x400) coincident with rsp_valid and Stall=1 → response dropped; IFID_valid=0 next edge; next request addr 0x400.
- PC=0xFFFF_FFFC sequential fetch → next request addr 0x0000_0000. Separately, rst_n low mid-WAIT → imem_req_valid=0, IFID_valid=0, IFID_instr=NOP immediately without a clock edge; after release, first request addr is RESET_PC.
